// File: rtl/frame_downloader_pkg.sv
// -----------------------------------------------------------------------------
// frame_downloader_pkg
// Shared types and geometry helpers for the PSRAM frame read path.
//   t_state      : download FSM states
//   burst_words  : 32-bit words per PSRAM burst
//   row_words    : 32-bit words per frame row (two RGB565 pixels per word)
//   addr_step    : PSRAM address advance per burst (PSRAM is 16-bit addressed)
//   burst_delay  : cycles the arbiter request is held after the last word of
//                  a burst so the PSRAM controller can close the access
// -----------------------------------------------------------------------------
package frame_downloader_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_BANK  = 3'd1,
        S_REQ        = 3'd2,
        S_CMD        = 3'd3,
        S_DATA       = 3'd4,
        S_RELEASE    = 3'd5,
        S_ROW_DONE   = 3'd6,
        S_FRAME_DONE = 3'd7
    } t_state;

    function automatic int burst_words(input int memory_burst);
        return memory_burst / 4;
    endfunction

    function automatic int row_words(input int frame_width);
        return frame_width / 2;
    endfunction

    function automatic int addr_step(input int memory_burst);
        return memory_burst / 2;
    endfunction

    // One cycle per 16 bytes of burst, never less than one cycle.
    function automatic int burst_delay(input int memory_burst);
        return (memory_burst / 16 < 1) ? 1 : memory_burst / 16;
    endfunction

endpackage

// File: rtl/frame_downloader_line_bank_tracker.sv
// -----------------------------------------------------------------------------
// frame_downloader_line_bank_tracker
// Per-bank "row complete, not yet drained" flags for the two-bank line cache.
//   clk          in   clock
//   reset_n      in   asynchronous active-low reset
//   i_set        in   2  one-cycle pulse: writer finished a row into bank b
//   i_clear      in   2  one-cycle pulse: display drained bank b
//   o_row_ready  out  2  flag per bank
// A set and a clear on the same bank in the same cycle leaves the flag set,
// so a freshly completed row can never be lost to a stale drain pulse.
// -----------------------------------------------------------------------------
module frame_downloader_line_bank_tracker (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_set,
    input  logic [1:0] i_clear,
    output logic [1:0] o_row_ready
);

    logic [1:0] r_row_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_ready <= 2'b00;
        end else begin
            r_row_ready <= (r_row_ready & ~i_clear) | i_set;
        end
    end

    assign o_row_ready = r_row_ready;

endmodule

// File: rtl/frame_downloader.sv
// -----------------------------------------------------------------------------
// frame_downloader
// Fetches a stored RGB565 frame from PSRAM, burst by burst and row by row, into
// a two-bank line cache. Rows alternate between bank 0 and bank 1 so the
// display can drain one bank while the other is being filled.
//   clk, reset_n      clock / asynchronous active-low reset
//   start, base_addr  frame start (level, sampled in IDLE) and PSRAM address of pixel (0,0)
//   read_rq/read_ack  arbiter request (held for whole burst) / grant
//   read_addr         burst start address, valid while mem_rd_en is high
//   mem_rd_en         one-cycle read command strobe per grant
//   read_data(_valid) returned words, [15:0] = even column
//   cache_addr/data/wr_en  registered line-cache write port, addr = {bank, word}
//   row_ready         per-bank completed-row flags; row_consumed clears them
//   frame_active      high while a frame download is in progress
//   download_done     one-cycle pulse after the last row has been written
// -----------------------------------------------------------------------------
module frame_downloader
    import frame_downloader_pkg::*;
#(
    parameter int MEMORY_BURST = 32,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [20:0] base_addr,
    output logic        read_rq,
    input  logic        read_ack,
    output logic [20:0] read_addr,
    output logic        mem_rd_en,
    input  logic [31:0] read_data,
    input  logic        read_data_valid,
    output logic [9:0]  cache_addr,
    output logic [31:0] cache_data,
    output logic        cache_wr_en,
    output logic [1:0]  row_ready,
    input  logic [1:0]  row_consumed,
    output logic        frame_active,
    output logic        download_done
);

    localparam logic [20:0] ADDR_STEP_V = 21'(addr_step(MEMORY_BURST));
    localparam logic [4:0]  LAST_BEAT   = 5'(burst_words(MEMORY_BURST) - 1);
    localparam logic [8:0]  LAST_WORD   = 9'(row_words(FRAME_WIDTH) - 1);
    localparam logic [9:0]  LAST_ROW    = 10'(FRAME_HEIGHT - 1);
    localparam logic [3:0]  REL_LAST    = 4'(burst_delay(MEMORY_BURST));

    t_state      r_state;
    t_state      w_state_next;
    logic [20:0] r_frame_addr;
    logic        r_bank;
    logic [9:0]  r_row;
    logic [8:0]  r_word;
    logic [4:0]  r_beat;
    logic [3:0]  r_dly;
    logic        r_row_complete;
    logic [9:0]  r_cache_addr;
    logic [31:0] r_cache_data;
    logic        r_cache_wr_en;
    logic [1:0]  w_set;
    logic        w_take_word;

    // Only words that arrive while a burst is being collected reach the cache.
    assign w_take_word = (r_state == S_DATA) && read_data_valid;

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_next  = r_state;
        read_rq       = 1'b0;
        mem_rd_en     = 1'b0;
        download_done = 1'b0;
        frame_active  = 1'b0;
        w_set         = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_WAIT_BANK;
            end
            S_WAIT_BANK: begin
                frame_active = 1'b1;
                if (!row_ready[r_bank]) w_state_next = S_REQ;
            end
            S_REQ: begin
                frame_active = 1'b1;
                read_rq      = 1'b1;
                if (read_ack) w_state_next = S_CMD;
            end
            S_CMD: begin
                frame_active = 1'b1;
                read_rq      = 1'b1;
                mem_rd_en    = 1'b1;
                w_state_next = S_DATA;
            end
            S_DATA: begin
                frame_active = 1'b1;
                read_rq      = 1'b1;
                if (read_data_valid && (r_beat == LAST_BEAT)) w_state_next = S_RELEASE;
            end
            S_RELEASE: begin
                frame_active = 1'b1;
                if (r_dly != REL_LAST) begin
                    read_rq = 1'b1;
                end else if (r_row_complete) begin
                    w_state_next = S_ROW_DONE;
                end else if (!read_ack) begin
                    // Re-request only once the arbiter has seen the release.
                    w_state_next = S_REQ;
                end
            end
            S_ROW_DONE: begin
                frame_active  = 1'b1;
                w_set[r_bank] = 1'b1;
                w_state_next  = (r_row == LAST_ROW) ? S_FRAME_DONE : S_WAIT_BANK;
            end
            S_FRAME_DONE: begin
                download_done = 1'b1;
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_frame_addr   <= 21'd0;
            r_bank         <= 1'b0;
            r_row          <= 10'd0;
            r_word         <= 9'd0;
            r_beat         <= 5'd0;
            r_dly          <= 4'd0;
            r_row_complete <= 1'b0;
            r_cache_addr   <= 10'd0;
            r_cache_data   <= 32'd0;
            r_cache_wr_en  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cache_wr_en <= w_take_word;
            if (w_take_word) begin
                r_cache_data <= read_data;
                r_cache_addr <= {r_bank, r_word};
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_frame_addr <= base_addr;
                        r_row        <= 10'd0;
                        r_word       <= 9'd0;
                        r_bank       <= 1'b0;
                    end
                end
                S_WAIT_BANK: begin
                    r_word         <= 9'd0;
                    r_row_complete <= 1'b0;
                end
                S_CMD: begin
                    // 21-bit address space wraps naturally.
                    r_frame_addr <= r_frame_addr + ADDR_STEP_V;
                    r_beat       <= 5'd0;
                end
                S_DATA: begin
                    if (read_data_valid) begin
                        r_beat <= r_beat + 5'd1;
                        r_dly  <= 4'd0;
                        if (r_word == LAST_WORD) begin
                            r_word         <= 9'd0;
                            r_row_complete <= 1'b1;
                        end else begin
                            r_word <= r_word + 9'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (r_dly != REL_LAST) r_dly <= r_dly + 4'd1;
                end
                S_ROW_DONE: begin
                    r_bank <= ~r_bank;
                    r_row  <= r_row + 10'd1;
                end
                default: ;
            endcase
        end
    end

    assign read_addr   = r_frame_addr;
    assign cache_addr  = r_cache_addr;
    assign cache_data  = r_cache_data;
    assign cache_wr_en = r_cache_wr_en;

    frame_downloader_line_bank_tracker u_bank_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_set       (w_set),
        .i_clear     (row_consumed),
        .o_row_ready (row_ready)
    );

endmodule

// File: tb/tb_frame_downloader.sv
// -----------------------------------------------------------------------------
// tb_frame_downloader
// Scoreboard bench for frame_downloader on a 32x4 frame. Every frame start
// pushes the expected burst addresses and cache writes (derived from base
// address and frame geometry) into queues; a monitor pops and compares them as
// the DUT produces commands and cache writes. A PSRAM/arbiter model returns
// address-tagged words with random grant latency and random gaps, and a
// display model drains banks under test control.
// -----------------------------------------------------------------------------
module tb_frame_downloader;

    localparam int FW  = 32;
    localparam int FH  = 4;
    localparam int MB  = 32;
    localparam int BPR = FW / 16;   // bursts per row
    localparam int BW  = MB / 4;    // words per burst

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [20:0] base_addr;
    logic        read_rq;
    logic        read_ack;
    logic [20:0] read_addr;
    logic        mem_rd_en;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic [9:0]  cache_addr;
    logic [31:0] cache_data;
    logic        cache_wr_en;
    logic [1:0]  row_ready;
    logic [1:0]  row_consumed;
    logic        frame_active;
    logic        download_done;

    always #5 clk = ~clk;

    frame_downloader #(
        .MEMORY_BURST (MB),
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .read_rq         (read_rq),
        .read_ack        (read_ack),
        .read_addr       (read_addr),
        .mem_rd_en       (mem_rd_en),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .cache_addr      (cache_addr),
        .cache_data      (cache_data),
        .cache_wr_en     (cache_wr_en),
        .row_ready       (row_ready),
        .row_consumed    (row_consumed),
        .frame_active    (frame_active),
        .download_done   (download_done)
    );

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } exp_wr_t;

    exp_wr_t     wr_q[$];
    logic [20:0] addr_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;
    int rd_count = 0;
    int grant_count = 0;
    int n_done = 0;
    int ack_fixed = -1;      // -1: random grant latency
    int cons_mode = 0;       // 0 auto drain, 1 hold bank0 drain, 2 off, 3 single bank0 pulse
    bit collision_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: frame geometry -> burst addresses and cache writes.
    task automatic push_frame(input logic [20:0] base);
        logic [20:0] a;
        exp_wr_t     e;
        for (int r = 0; r < FH; r++) begin
            for (int k = 0; k < BPR; k++) begin
                a = base + 21'((r * BPR + k) * 16);
                addr_q.push_back(a);
                for (int j = 0; j < BW; j++) begin
                    e.addr = {1'(r % 2), 9'(k * BW + j)};
                    e.data = {3'b000, a, 8'(j)};
                    wr_q.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_writes(input int target, input int budget, input string name);
        int i = 0;
        while (wr_count < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 64'(wr_count >= target), 64'd1);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int i = 0;
        while (n_done < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 64'(n_done >= target), 64'd1);
    endtask

    task automatic drain_ready();
        int i = 0;
        cons_mode = 0;
        while (row_ready != 2'b00 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("ready drained before frame", 64'(row_ready), 64'd0);
    endtask

    task automatic pulse_start(input logic [20:0] b);
        base_addr = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = 21'($urandom);   // latched on start; later changes must not matter
    endtask

    // ------------------------------------------------------------ monitor
    initial begin
        bit      prev_rd = 1'b0;
        exp_wr_t e;
        logic [20:0] ea;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (cache_wr_en) begin
                    wr_count++;
                    $display("[%0t] cache write addr=0x%03h data=0x%08h", $time, cache_addr, cache_data);
                    if (wr_q.size() == 0) begin
                        check("cache write with empty scoreboard", 64'(wr_q.size()), 64'd1);
                    end else begin
                        e = wr_q.pop_front();
                        check("cache_addr", 64'(cache_addr), 64'(e.addr));
                        check("cache_data", 64'(cache_data), 64'(e.data));
                    end
                end
                if (mem_rd_en) begin
                    rd_count++;
                    $display("[%0t] burst command addr=0x%06h", $time, read_addr);
                    check("mem_rd_en single-cycle", 64'(prev_rd), 64'd0);
                    if (addr_q.size() == 0) begin
                        check("burst command with empty scoreboard", 64'(addr_q.size()), 64'd1);
                    end else begin
                        ea = addr_q.pop_front();
                        check("read_addr", 64'(read_addr), 64'(ea));
                    end
                end
                prev_rd = mem_rd_en;
                if (download_done) begin
                    n_done++;
                    $display("[%0t] download_done", $time);
                end
            end else begin
                prev_rd = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ PSRAM / arbiter model
    initial begin
        int          m_st = 0;
        int          m_cnt = 0;
        int          m_to = 0;
        int          m_beat = 0;
        int          m_gap = 0;
        logic [20:0] m_addr = 21'd0;
        read_ack        = 1'b0;
        read_data_valid = 1'b0;
        read_data       = 32'd0;
        forever begin
            @(negedge clk);
            read_data_valid = 1'b0;
            if (!reset_n) begin
                read_ack = 1'b0;
                m_st     = 0;
            end else begin
                case (m_st)
                    0: begin
                        read_ack = 1'b0;
                        if (read_rq) begin
                            m_cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
                            m_st  = 1;
                        end else if ($urandom_range(0, 5) == 0) begin
                            read_data_valid = 1'b1;     // stray word, must be ignored
                            read_data       = $urandom;
                        end
                    end
                    1: begin
                        if (m_cnt == 0) begin
                            read_ack = 1'b1;
                            grant_count++;
                            m_to = 0;
                            m_st = 2;
                        end else begin
                            m_cnt--;
                        end
                    end
                    2: begin
                        if (mem_rd_en) begin
                            m_addr = read_addr;
                            m_beat = 0;
                            m_gap  = $urandom_range(0, 2);
                            m_st   = 3;
                        end else begin
                            m_to++;
                            if (m_to > 4) begin
                                check("mem_rd_en after grant", 64'(mem_rd_en), 64'd1);
                                m_st = 4;
                            end
                        end
                    end
                    3: begin
                        if (m_gap > 0) begin
                            m_gap--;
                        end else begin
                            read_data_valid = 1'b1;
                            read_data       = {3'b000, m_addr, 8'(m_beat)};
                            m_beat++;
                            m_gap = $urandom_range(0, 2);
                            if (m_beat == BW) m_st = 4;
                        end
                    end
                    default: begin
                        if (!read_rq) begin
                            read_ack = 1'b0;
                            m_st     = 0;
                        end else if ($urandom_range(0, 3) == 0) begin
                            read_data_valid = 1'b1;     // stray word during release
                            read_data       = $urandom;
                        end
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------ display model
    initial begin
        bit pulsed = 1'b0;
        row_consumed = 2'b00;
        forever begin
            @(negedge clk);
            row_consumed = 2'b00;
            if (cons_mode != 1) collision_seen = 1'b0;
            if (cons_mode != 3) pulsed = 1'b0;
            if (reset_n) begin
                case (cons_mode)
                    0: row_consumed = row_ready & 2'($urandom_range(0, 3));
                    1: begin
                        if (!collision_seen) begin
                            if (row_ready[0]) collision_seen = 1'b1;
                            else              row_consumed   = 2'b01;
                        end
                    end
                    3: begin
                        if (!pulsed) begin
                            row_consumed = 2'b01;
                            pulsed       = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------ main sequence
    initial begin
        int          w0;
        int          r0;
        int          g0;
        int          d0;
        int          i;
        logic [20:0] b;

        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = 21'd0;
        repeat (3) @(negedge clk);
        check("reset read_rq",       64'(read_rq),       64'd0);
        check("reset mem_rd_en",     64'(mem_rd_en),     64'd0);
        check("reset cache_wr_en",   64'(cache_wr_en),   64'd0);
        check("reset row_ready",     64'(row_ready),     64'd0);
        check("reset frame_active",  64'(frame_active),  64'd0);
        check("reset download_done", 64'(download_done), 64'd0);
        check("reset read_addr",     64'(read_addr),     64'd0);
        check("reset cache_addr",    64'(cache_addr),    64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: base 0x100, random grant latency, display drains freely.
        r0 = rd_count;
        push_frame(21'h000100);
        pulse_start(21'h000100);
        check("frame_active after start", 64'(frame_active), 64'd1);
        wait_done(1, 4000, "frame1 done");
        check("frame1 frame_active low", 64'(frame_active), 64'd0);
        check("frame1 bursts", 64'(rd_count - r0), 64'(FH * BPR));
        repeat (5) @(negedge clk);
        check("frame1 done single pulse", 64'(n_done), 64'd1);
        check("frame1 writes pending", 64'(wr_q.size()), 64'd0);

        // Frame 2: 20-cycle grant latency, drain/set collision on bank 0, then stall.
        drain_ready();
        ack_fixed = 20;
        w0 = wr_count; r0 = rd_count; g0 = grant_count; d0 = n_done;
        b = 21'($urandom);
        push_frame(b);
        cons_mode = 1;
        pulse_start(b);
        i = 0;
        while (!collision_seen && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check("set wins over same-cycle consume", 64'(collision_seen), 64'd1);
        cons_mode = 2;
        wait_writes(w0 + 2 * FW / 2, 3000, "two rows written");
        repeat (40) @(negedge clk);
        check("stall row_ready",    64'(row_ready),    64'd3);
        check("stall read_rq",      64'(read_rq),      64'd0);
        check("stall frame_active", 64'(frame_active), 64'd1);
        check("stall no extra writes", 64'(wr_count - w0), 64'(2 * FW / 2));
        cons_mode = 3;
        repeat (3) @(negedge clk);
        cons_mode = 2;
        wait_writes(w0 + 3 * FW / 2, 3000, "row 2 written after bank0 drain");
        cons_mode = 0;
        wait_done(d0 + 1, 4000, "frame2 done");
        check("one command per grant", 64'(rd_count - r0), 64'(grant_count - g0));
        check("frame2 writes", 64'(wr_count - w0), 64'(FH * FW / 2));
        ack_fixed = -1;

        // Frame 3: address wrap at top of PSRAM.
        drain_ready();
        d0 = n_done;
        push_frame(21'h1FFFF0);
        pulse_start(21'h1FFFF0);
        wait_done(d0 + 1, 4000, "frame3 done");
        check("frame3 addresses pending", 64'(addr_q.size()), 64'd0);

        // Frame 4: reset in the middle of a burst on the second row.
        drain_ready();
        cons_mode = 2;
        w0 = wr_count; d0 = n_done;
        b = 21'($urandom);
        push_frame(b);
        pulse_start(b);
        wait_writes(w0 + FW / 2 + 4, 3000, "mid-burst point reached");
        check("pre-reset row_ready", 64'(row_ready), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async reset read_rq",     64'(read_rq),     64'd0);
        check("async reset cache_wr_en", 64'(cache_wr_en), 64'd0);
        check("async reset row_ready",   64'(row_ready),   64'd0);
        check("async reset frame_active", 64'(frame_active), 64'd0);
        wr_q.delete();
        addr_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post reset idle", 64'(frame_active), 64'd0);

        // Frames 5/6: start held high across FRAME_DONE restarts from IDLE.
        cons_mode = 0;
        d0 = n_done;
        b = 21'($urandom);
        push_frame(b);
        push_frame(b);
        base_addr = b;
        start     = 1'b1;
        wait_done(d0 + 1, 4000, "frame5 done");
        i = 0;
        while (!frame_active && i < 20) begin
            @(negedge clk);
            i++;
        end
        start = 1'b0;
        check("held start restarts", 64'(frame_active), 64'd1);
        wait_done(d0 + 2, 4000, "frame6 done");
        repeat (5) @(negedge clk);
        check("final writes pending",    64'(wr_q.size()),   64'd0);
        check("final addresses pending", 64'(addr_q.size()), 64'd0);
        check("final frame_active",      64'(frame_active),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
